keypad_in: RTL

- Memory-mapped input peripheral: the input-side counterpart of the 16-bit decimal 7-seg output device.
- Scans a 4x4 matrix keypad, debounces presses and assembles a decimal number of up to 4 digits (0..9999).
- On the confirm key, presents the number to the CPU as a 16-bit read word with a read-to-clear valid flag.
- Sits on the memorio bus next to the LED/7-seg block; kb_entry can be routed to that block to echo typing.

---
 rtl/keypad_in.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_in.sv
// -----------------------------------------------------------------------------
// keypad_in
//
// Memory-mapped keypad input peripheral. The block scans a 4x4 matrix keypad
// and debounces each press and release. It builds a decimal number of up to
// four digits (0..9999). When the confirm key (#) is pressed, it hands that
// number to the CPU as a 16-bit read word with a read-to-clear valid flag.
//
// Key map (row r, column c; column c is active when kb_col[c] == 0):
//   r0: 1 2 3 A    r1: 4 5 6 B    r2: 7 8 9 C    r3: * 0 # D
//   A = backspace, * = clear, # = confirm, B/C/D = no effect.
//
// Ports:
//   kb_clk    in   system clock, all logic on the rising edge
//   kbrst     in   synchronous active-high reset
//   kbread    in   one-cycle CPU read strobe, clears kb_valid
//   kb_row    in   [3:0] keypad rows, active-low, asynchronous to kb_clk
//   kb_col    out  [3:0] keypad column drive, one-cold
//   kbrdata   out  [15:0] last confirmed value (binary, 0..9999)
//   kb_valid  out  confirmed value not yet read
//   kb_entry  out  [15:0] number currently being typed (binary, 0..9999)
// -----------------------------------------------------------------------------
module keypad_in #(
  parameter int SCAN_PERIOD = 20000,
  parameter int DEBOUNCE    = 200000
) (
  input  logic        kb_clk,
  input  logic        kbrst,
  input  logic        kbread,
  input  logic [3:0]  kb_row,
  output logic [3:0]  kb_col,
  output logic [15:0] kbrdata,
  output logic        kb_valid,
  output logic [15:0] kb_entry
);

  // One counter serves the scan period and both debounce windows, so it must
  // be wide enough for the longer of the two.
  localparam int CNT_MAX = (SCAN_PERIOD > DEBOUNCE) ? SCAN_PERIOD : DEBOUNCE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_PERIOD - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE - 1);

  typedef enum logic [2:0] {
    ST_SCAN,
    ST_DEB_PRESS,
    ST_ACT,
    ST_WAIT_REL,
    ST_DEB_REL
  } state_e;

  // Digit keys use their numeric value as the code, so the code can be added
  // straight into the entry value.
  typedef enum logic [3:0] {
    K_0, K_1, K_2, K_3, K_4, K_5, K_6, K_7, K_8, K_9,
    K_A, K_B, K_C, K_D, K_STAR, K_HASH
  } key_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       col_q, col_d;
  logic [3:0]       cap_q, cap_d;      // row pattern captured at press start
  logic [3:0]       row_s1_q, row_s2_q;
  logic [15:0]      entry_q, entry_d;
  logic [15:0]      rdata_q, rdata_d;
  logic             valid_q, valid_d;

  logic [3:0]       row;
  logic [1:0]       row_idx, col_idx;
  key_e             key;
  logic [16:0]      append;

  assign row = row_s2_q;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples values from before the edge regardless of statement order.
  always_ff @(posedge kb_clk) begin
    if (kbrst) begin
      // NOTE: the synchronizer resets to "no key" (all rows high). Otherwise
      // the first cycles after reset could see a phantom press.
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
      state_q  <= ST_SCAN;
      cnt_q    <= '0;
      col_q    <= 4'b1110;
      cap_q    <= 4'hF;
      entry_q  <= '0;
      rdata_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      row_s1_q <= kb_row;
      row_s2_q <= row_s1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      col_q    <= col_d;
      cap_q    <= cap_d;
      entry_q  <= entry_d;
      rdata_q  <= rdata_d;
      valid_q  <= valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: scanning, debouncing and column rotation
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first. A path that leaves
  // a signal unassigned would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    cap_d   = cap_q;
    unique case (state_q)
      ST_SCAN: begin
        if (row != 4'hF) begin
          // A press freezes the column, so the decode sees the column that
          // was driven when the press was seen.
          cap_d   = row;
          cnt_d   = '0;
          state_d = ST_DEB_PRESS;
        end else if (cnt_q == SCAN_LAST) begin
          col_d = {col_q[2:0], col_q[3]};
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DEB_PRESS: begin
        if (row != cap_q) begin
          cnt_d   = '0;
          state_d = ST_SCAN;
        end else if (cnt_q == DEB_LAST) begin
          cnt_d   = '0;
          state_d = ST_ACT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ACT: begin
        state_d = ST_WAIT_REL;
      end
      ST_WAIT_REL: begin
        if (row == 4'hF) begin
          cnt_d   = '0;
          state_d = ST_DEB_REL;
        end
      end
      ST_DEB_REL: begin
        if (row != 4'hF) begin
          state_d = ST_WAIT_REL;
        end else if (cnt_q == DEB_LAST) begin
          cnt_d   = '0;
          state_d = ST_SCAN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_SCAN;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Key decode. When several rows are low, the lowest row index wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    row_idx = 2'd0;
    col_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!cap_q[i]) row_idx = 2'(i);
      if (!col_q[i]) col_idx = 2'(i);
    end
    case ({row_idx, col_idx})
      4'd0:    key = K_1;
      4'd1:    key = K_2;
      4'd2:    key = K_3;
      4'd3:    key = K_A;
      4'd4:    key = K_4;
      4'd5:    key = K_5;
      4'd6:    key = K_6;
      4'd7:    key = K_B;
      4'd8:    key = K_7;
      4'd9:    key = K_8;
      4'd10:   key = K_9;
      4'd11:   key = K_C;
      4'd12:   key = K_STAR;
      4'd13:   key = K_0;
      4'd14:   key = K_HASH;
      default: key = K_D;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: key actions and CPU read handshake
  // ---------------------------------------------------------------------------
  always_comb begin
    entry_d = entry_q;
    rdata_d = rdata_q;
    valid_d = valid_q;
    // 9999 * 10 + 9 still fits in 17 bits, so the overflow test cannot wrap.
    append  = 17'(entry_q) * 17'd10 + 17'(key);

    if (kbread) valid_d = 1'b0;

    // The action is applied after the read clear, so a confirm that lands on
    // the same cycle as a read leaves the flag set.
    if (state_q == ST_ACT) begin
      case (key)
        K_0, K_1, K_2, K_3, K_4, K_5, K_6, K_7, K_8, K_9: begin
          if (append <= 17'd9999) entry_d = append[15:0];
        end
        K_A:     entry_d = entry_q / 16'd10;
        K_STAR:  entry_d = '0;
        K_HASH: begin
          rdata_d = entry_q;
          valid_d = 1'b1;
          entry_d = '0;
        end
        default: ;
      endcase
    end
  end

  assign kb_col   = col_q;
  assign kbrdata  = rdata_q;
  assign kb_valid = valid_q;
  assign kb_entry = entry_q;

endmodule
